writeback_regfile: RTL and testbench
====================================

// Module: writeback_regfile
// PURPOSE
//   Consumer end of the MEM->WB pipeline register: takes the W-stage bundle, selects and
//   extracts the writeback result, and writes it into the 32x32 integer register file.
//   Serves the two decode-stage read ports and drives the W-stage result back for EX forwarding.
//   Writes on the falling clock edge, so decode reads in the second half of the cycle see them.
// PARAMETERS
//   DATA_WIDTH     32  register / datapath width
//   ADDRESS_WIDTH  32  PC width (pc_plus4W_i)
//   CNT_WIDTH      32  width of the retired-writeback counter
// PORTS
//   clk_i           in   1    clock; RF write on negedge, counter on posedge
//   rst_i           in   1    asynchronous, active-high reset
//   alu_resultW_i   in   DW   ALU result; also load address (bits [1:0] select lane)
//   read_dataW_i    in   DW   raw 32-bit word from data memory
//   pc_plus4W_i     in   AW   PC+4 for JAL/JALR link
//   rdW_i           in   5    destination register
//   reg_writeW_i    in   1    write enable
//   result_srcW_i   in   2    00 ALU, 01 load, 10 PC+4, 11 ALU
//   funct3W_i       in   3    load size/sign for extraction
//   rs1D_i          in   5    decode read address 1
//   rs2D_i          in   5    decode read address 2
//   rd1D_o          out  DW   register[rs1D_i]
//   rd2D_o          out  DW   register[rs2D_i]
//   resultW_o       out  DW   selected writeback value (to forwarding mux)
//   a0_o            out  DW   register x10, for top-level observation
//   wb_count_o      out  CW   count of committed writebacks
// BEHAVIOUR
//   - Reset (rst_i high, any time): all 32 registers, a0_o, wb_count_o clear to 0 immediately.
//     Writes and counting are suppressed while rst_i is high.
//   - Load extraction (combinational), lane = alu_resultW_i[1:0]:
//     000 LB  byte[lane], sign-extended    100 LBU byte[lane], zero-extended
//     001 LH  half[lane[1]], sign-extended 101 LHU half[lane[1]], zero-extended
//     010 LW  full word; 011/110/111 treated as LW. lane[0] ignored for halfwords.
//     byte[n] = read_dataW_i[8n+7:8n] (little-endian).
//   - resultW_o = mux(result_srcW_i) over ALU / extracted load / pc_plus4W_i; combinational,
//     valid whatever reg_writeW_i is.
//   - Write: at each falling edge of clk_i, if reg_writeW_i && rdW_i != 0,
//     then reg[rdW_i] <= resultW_o.
//   - x0: reads always return 0; writes to x0 are discarded and not counted.
//   - Reads: rd1D_o/rd2D_o are combinational from the array.
//     A read of the register written at this cycle's falling edge returns the old value
//     before that edge and the new value after it; no further bypass.
//   - rs1D_i == rs2D_i: both ports return the same value.
//   - wb_count_o: +1 at each rising edge where reg_writeW_i && rdW_i != 0 (sampled then).
//     Wraps 2^CW-1 -> 0 silently.
//   - a0_o always mirrors reg[10].
//   - Latency: write visible half a cycle after the W-stage inputs settle; resultW_o has
//     zero latency.
// TESTING
//   1 Reset: preload x5=0x1234, assert rst_i mid-cycle -> rd1D_o(x5)=0, wb_count_o=0 at once.
//   2 ALU write: rd=5, src=00, alu=0xDEADBEEF, we=1 -> after negedge rd1D_o(x5)=0xDEADBEEF;
//     wb_count_o +1 at the next posedge.
//   3 Loads: read_data=0x8070F0A5, addr[1:0]=2: LB -> 0x00000070; addr 3 LB -> 0xFFFFFF80;
//     addr 0 LH -> 0xFFFFF0A5; addr 2 LHU -> 0x00008070; LW -> 0x8070F0A5.
//   4 x0: we=1, rd=0, alu=0xFFFFFFFF -> rd1D_o(x0)=0, wb_count_o unchanged.
//   5 Same-cycle: write x10=0x42 while rs1D_i=10 -> old value before negedge, 0x42 after;
//     a0_o=0x42.
//   6 Link + wrap: src=10, pc_plus4=0x104, rd=1 -> x1=0x104. Counter at all-ones plus one
//     write -> 0.

Source files
------------

// File: rtl/writeback_regfile_if.sv
// rtl/writeback_regfile_if.sv - W-stage bundle, decode read ports and observation outputs of the writeback register file
interface writeback_regfile_if #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int CW = 32
);
    logic [DW-1:0] alu_resultW_i;
    logic [DW-1:0] read_dataW_i;
    logic [AW-1:0] pc_plus4W_i;
    logic [4:0]    rdW_i;
    logic          reg_writeW_i;
    logic [1:0]    result_srcW_i;
    logic [2:0]    funct3W_i;
    logic [4:0]    rs1D_i;
    logic [4:0]    rs2D_i;
    logic [DW-1:0] rd1D_o;
    logic [DW-1:0] rd2D_o;
    logic [DW-1:0] resultW_o;
    logic [DW-1:0] a0_o;
    logic [CW-1:0] wb_count_o;

    modport master (
        output alu_resultW_i, read_dataW_i, pc_plus4W_i, rdW_i, reg_writeW_i,
               result_srcW_i, funct3W_i, rs1D_i, rs2D_i,
        input  rd1D_o, rd2D_o, resultW_o, a0_o, wb_count_o
    );

    modport slave (
        input  alu_resultW_i, read_dataW_i, pc_plus4W_i, rdW_i, reg_writeW_i,
               result_srcW_i, funct3W_i, rs1D_i, rs2D_i,
        output rd1D_o, rd2D_o, resultW_o, a0_o, wb_count_o
    );
endinterface

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - W-stage result select/load extraction and 32x32 register file written on the falling edge
module writeback_regfile #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    writeback_regfile_if.slave   wb
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = CNT_WIDTH;

    logic [DW-1:0] regs_q [32];
    logic [DW-1:0] regs_d [32];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic [1:0]    lane;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [DW-1:0] load_val;
    logic [DW-1:0] result;
    logic          wb_en;

    assign lane     = wb.alu_resultW_i[1:0];
    assign byte_sel = wb.read_dataW_i[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? wb.read_dataW_i[31:16] : wb.read_dataW_i[15:0];
    assign wb_en    = wb.reg_writeW_i && (wb.rdW_i != 5'd0);

    always_comb begin
        load_val = wb.read_dataW_i;
        case (wb.funct3W_i)
            3'b000:  load_val = {{(DW-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{(DW-16){half_sel[15]}}, half_sel};
            3'b100:  load_val = {{(DW-8){1'b0}}, byte_sel};
            3'b101:  load_val = {{(DW-16){1'b0}}, half_sel};
            default: load_val = wb.read_dataW_i;
        endcase
    end

    always_comb begin
        result = wb.alu_resultW_i;
        case (wb.result_srcW_i)
            2'b01:   result = load_val;
            2'b10:   result = DW'(wb.pc_plus4W_i);
            default: result = wb.alu_resultW_i;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_en) begin
            regs_d[wb.rdW_i] = result;
        end
    end

    // Falling-edge write lets decode read the new value in the second half of the cycle.
    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (wb_en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wb.resultW_o  = result;
    assign wb.rd1D_o     = (wb.rs1D_i == 5'd0) ? '0 : regs_q[wb.rs1D_i];
    assign wb.rd2D_o     = (wb.rs2D_i == 5'd0) ? '0 : regs_q[wb.rs2D_i];
    assign wb.a0_o       = regs_q[10];
    assign wb.wb_count_o = cnt_q;
endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - self-checking bench for writeback_regfile
module tb_writeback_regfile;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    writeback_regfile_if #(.DW(DW), .AW(AW), .CW(CW)) bus();

    writeback_regfile #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .wb   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m_regs [32];
    int unsigned m_cnt;

    typedef struct {
        string       name;
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] src, input logic [2:0] f3,
                                               input logic [31:0] alu, input logic [31:0] rdata,
                                               input logic [31:0] pc);
        int unsigned v;
        if (src == 2'd2) return pc;
        if (src != 2'd1) return alu;
        case (f3)
            3'd0, 3'd4: begin
                v = (rdata >> ((alu % 4) * 8)) & 32'hFF;
                if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFFFF00;
            end
            3'd1, 3'd5: begin
                v = (rdata >> (((alu % 4) / 2) * 16)) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF0000;
            end
            default: v = rdata;
        endcase
        return v;
    endfunction

    task automatic drive(input logic we, input logic [4:0] rd, input logic [1:0] src,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2);
        bus.reg_writeW_i  = we;
        bus.rdW_i         = rd;
        bus.result_srcW_i = src;
        bus.funct3W_i     = f3;
        bus.alu_resultW_i = alu;
        bus.read_dataW_i  = rdata;
        bus.pc_plus4W_i   = pc;
        bus.rs1D_i        = rs1;
        bus.rs2D_i        = rs2;
    endtask

    // Entered and left just after a rising edge; covers one full W-stage cycle.
    task automatic step(input string tag, input logic we, input logic [4:0] rd, input logic [1:0] src,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2);
        logic [31:0] res;
        drive(we, rd, src, f3, alu, rdata, pc, rs1, rs2);
        #1;
        res = ref_result(src, f3, alu, rdata, pc);
        chk({tag, "/result"}, bus.resultW_o, res);
        chk({tag, "/rd1_before"}, bus.rd1D_o, m_regs[rs1]);
        @(negedge clk);
        #1;
        if (we && rd != 5'd0) m_regs[rd] = res;
        chk({tag, "/rd1_after"}, bus.rd1D_o, m_regs[rs1]);
        chk({tag, "/rd2_after"}, bus.rd2D_o, m_regs[rs2]);
        chk({tag, "/a0"}, bus.a0_o, m_regs[10]);
        @(posedge clk);
        #1;
        if (we && rd != 5'd0) m_cnt = (m_cnt + 1) % (1 << CW);
        chk({tag, "/count"}, {28'd0, bus.wb_count_o}, m_cnt);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_cnt = 0;
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = '{"lb_a2",   2'd1, 3'd0, 32'h0000_0002, 32'h8070F0A5, 32'h0, 32'h00000070};
        vecs[1] = '{"lb_a3",   2'd1, 3'd0, 32'h0000_0003, 32'h8070F0A5, 32'h0, 32'hFFFFFF80};
        vecs[2] = '{"lh_a0",   2'd1, 3'd1, 32'h0000_0000, 32'h8070F0A5, 32'h0, 32'hFFFFF0A5};
        vecs[3] = '{"lhu_a2",  2'd1, 3'd5, 32'h0000_0002, 32'h8070F0A5, 32'h0, 32'h00008070};
        vecs[4] = '{"lw",      2'd1, 3'd2, 32'h0000_0000, 32'h8070F0A5, 32'h0, 32'h8070F0A5};
        vecs[5] = '{"lbu_a0",  2'd1, 3'd4, 32'h0000_0000, 32'h8070F0A5, 32'h0, 32'h000000A5};
        vecs[6] = '{"lh_a3",   2'd1, 3'd1, 32'h0000_0003, 32'h8070F0A5, 32'h0, 32'hFFFF8070};
        vecs[7] = '{"f3_7_lw", 2'd1, 3'd7, 32'h0000_0001, 32'h8070F0A5, 32'h0, 32'h8070F0A5};
        vecs[8] = '{"src11",   2'd3, 3'd0, 32'h1357_9BDF, 32'h8070F0A5, 32'h104, 32'h13579BDF};
        vecs[9] = '{"src10",   2'd2, 3'd0, 32'h1357_9BDF, 32'h8070F0A5, 32'h104, 32'h00000104};

        drive(1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        model_reset();
        #1 rst = 1'b1;
        #1;
        chk("reset/count", {28'd0, bus.wb_count_o}, 32'd0);
        chk("reset/a0", bus.a0_o, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(1'b0, 5'd3, vecs[i].src, vecs[i].f3, vecs[i].alu, vecs[i].rdata, vecs[i].pc, 5'd0, 5'd0);
            #1;
            chk({"table/", vecs[i].name}, bus.resultW_o, vecs[i].exp);
        end
        @(posedge clk);
        #1;
        chk("table/no_count", {28'd0, bus.wb_count_o}, 32'd0);

        step("alu_x5", 1'b1, 5'd5, 2'd0, 3'd0, 32'hDEADBEEF, 32'h0, 32'h0, 5'd5, 5'd5);
        chk("alu_x5/value", bus.rd1D_o, 32'hDEADBEEF);
        step("x0_write", 1'b1, 5'd0, 2'd0, 3'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0, 5'd5);
        chk("x0_write/read", bus.rd1D_o, 32'd0);
        step("x10_old", 1'b1, 5'd10, 2'd0, 3'd0, 32'h00000011, 32'h0, 32'h0, 5'd10, 5'd10);
        step("x10_new", 1'b1, 5'd10, 2'd0, 3'd0, 32'h00000042, 32'h0, 32'h0, 5'd10, 5'd10);
        chk("x10_new/a0", bus.a0_o, 32'h42);
        step("link_x1", 1'b1, 5'd1, 2'd2, 3'd0, 32'h0, 32'h0, 32'h104, 5'd1, 5'd10);
        chk("link_x1/value", bus.rd1D_o, 32'h104);
        step("load_x7", 1'b1, 5'd7, 2'd1, 3'd0, 32'h3, 32'h8070F0A5, 32'h0, 5'd7, 5'd1);
        chk("load_x7/value", bus.rd1D_o, 32'hFFFFFF80);

        // Asynchronous reset asserted mid-cycle, then writes held off while it stays high.
        step("pre_x5", 1'b1, 5'd5, 2'd0, 3'd0, 32'h00001234, 32'h0, 32'h0, 5'd5, 5'd5);
        drive(1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd10);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_mid/x5", bus.rd1D_o, 32'd0);
        chk("rst_mid/a0", bus.rd2D_o, 32'd0);
        chk("rst_mid/count", {28'd0, bus.wb_count_o}, 32'd0);
        drive(1'b1, 5'd5, 2'd0, 3'd0, 32'h00000055, 32'h0, 32'h0, 5'd5, 5'd5);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("rst_hold/x5", bus.rd1D_o, 32'd0);
        chk("rst_hold/count", {28'd0, bus.wb_count_o}, 32'd0);
        drive(1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 200; i++) begin
            logic [4:0] rd;
            rd = (i % 7 == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            step("rand", 1'($urandom), rd, 2'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                 5'($urandom), ((i % 5) == 0) ? rd : 5'($urandom));
        end

        while (m_cnt != (1 << CW) - 1) begin
            step("fill", 1'b1, 5'd20, 2'd0, 3'd0, $urandom, 32'h0, 32'h0, 5'd20, 5'd10);
        end
        chk("wrap/all_ones", {28'd0, bus.wb_count_o}, 32'd15);
        step("wrap", 1'b1, 5'd21, 2'd0, 3'd0, 32'hCAFE0001, 32'h0, 32'h0, 5'd21, 5'd20);
        chk("wrap/zero", {28'd0, bus.wb_count_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
